// File: rtl/cnn_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_mac_pkg
// Brief    : Shared widths, state encoding and saturation limits for the
//            CNN MAC requantisation path.
// Revision : 1.0
// ============================================================================
package cnn_mac_pkg;

    localparam int PROD_WIDTH = 41;
    localparam int ACC_WIDTH  = 48;
    localparam int OUT_WIDTH  = 18;
    localparam int FRAC_SHIFT = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Signed limits for the default accumulator and output widths
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/cnn_requant_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : cnn_requant_round_sat
// Brief    : Combinational round-half-up, arithmetic right shift and clamp
//            of a wide accumulator down to the activation width.
// Revision : 1.0
// ============================================================================
module cnn_requant_round_sat #(
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 18,
    parameter int FRAC_SHIFT = 14
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] data,
    output logic                        clamp_hit
);

    // One extra bit so adding the rounding constant can never wrap
    localparam logic signed [ACC_WIDTH:0] C_HALF =
        {{(ACC_WIDTH+1-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] C_OUT_MAX =
        {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] C_OUT_MIN = ~C_OUT_MAX;

    logic signed [ACC_WIDTH:0] w_rounded;
    logic signed [ACC_WIDTH:0] w_shifted;
    logic signed [ACC_WIDTH:0] w_clamped;

    // Round, shift, then clamp into the signed output range
    always_comb begin
        w_rounded = $signed({acc[ACC_WIDTH-1], acc}) + C_HALF;
        w_shifted = w_rounded >>> FRAC_SHIFT;
        clamp_hit = 1'b0;
        w_clamped = w_shifted;
        if (w_shifted > C_OUT_MAX) begin
            w_clamped = C_OUT_MAX;
            clamp_hit = 1'b1;
        end else if (w_shifted < C_OUT_MIN) begin
            w_clamped = C_OUT_MIN;
            clamp_hit = 1'b1;
        end
        data = OUT_WIDTH'(w_clamped);
    end

endmodule
`default_nettype wire

// File: rtl/cnn_mac_requant.sv
`default_nettype none
// ============================================================================
// Module   : cnn_mac_requant
// Brief    : Accumulates a window of signed DSP products plus an aligned
//            bias, then requantises to the activation format on a
//            valid/ready output.
// Revision : 1.0
// ============================================================================
module cnn_mac_requant #(
    parameter int PROD_WIDTH = cnn_mac_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH  = cnn_mac_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = cnn_mac_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT = cnn_mac_pkg::FRAC_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_last,
    input  logic [OUT_WIDTH-1:0]  bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  busy
);

    import cnn_mac_pkg::*;

    localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_sticky;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_sat;

    logic                   w_accept;
    logic [ACC_WIDTH-1:0]   w_bias_aligned;
    logic [ACC_WIDTH-1:0]   w_base;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_ovf;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic signed [OUT_WIDTH-1:0] w_rq_data;
    logic                   w_rq_clamp;

    assign prod_ready = (r_state == IDLE) || (r_state == ACCUM);
    assign out_valid  = (r_state == HOLD);
    assign busy       = (r_state != IDLE);
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;
    assign w_accept   = ce & prod_valid & prod_ready;

    // Saturating add; the first beat of a window starts from the aligned bias,
    // which cannot overflow the accumulator on its own
    always_comb begin
        w_bias_aligned = {{(ACC_WIDTH-OUT_WIDTH-FRAC_SHIFT){bias[OUT_WIDTH-1]}},
                          bias, {FRAC_SHIFT{1'b0}}};
        w_base = (r_state == IDLE) ? w_bias_aligned : r_acc;
        w_sum  = {w_base[ACC_WIDTH-1], w_base}
               + {{(ACC_WIDTH+1-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
        w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
        if (w_ovf) begin
            w_acc_next = w_sum[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX;
        end else begin
            w_acc_next = w_sum[ACC_WIDTH-1:0];
        end
    end

    cnn_requant_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .acc       ($signed(r_acc)),
        .data      (w_rq_data),
        .clamp_hit (w_rq_clamp)
    );

    // Next-state logic for the window / result handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = prod_last ? ROUND : ACCUM;
                end
            end
            ROUND: w_state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register, frozen while ce is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // Accumulator, sticky saturation flag and captured result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_sticky   <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (ce) begin
            if (w_accept) begin
                r_acc    <= w_acc_next;
                r_sticky <= ((r_state == IDLE) ? 1'b0 : r_sticky) | w_ovf;
            end
            if (r_state == ROUND) begin
                r_out_data <= w_rq_data;
                r_out_sat  <= r_sticky | w_rq_clamp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_mac_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_mac_requant
// Brief    : Directed self-checking bench for cnn_mac_requant.
// Revision : 1.0
// ============================================================================
module tb_cnn_mac_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        prod_valid;
    logic        prod_ready;
    logic [40:0] prod_data;
    logic        prod_last;
    logic [17:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    cnn_mac_requant dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one beat just after an edge; it is taken at the next edge
    task automatic beat(input longint d, input logic last);
        prod_valid = 1'b1;
        prod_data  = 41'(d);
        prod_last  = last;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    // Called right after the last beat's edge with out_ready high
    task automatic expect_result(input string tag, input int exp_d, input logic exp_s);
        check({tag, "_round_valid"}, 64'(out_valid), 0);
        check({tag, "_round_ready"}, 64'(prod_ready), 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 1);
        check({tag, "_data"},  $signed(out_data), exp_d);
        check({tag, "_sat"},   64'(out_sat), 64'(exp_s));
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 64'(out_valid), 0);
        check({tag, "_done_busy"},  64'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; prod_valid = 1'b0; prod_data = '0;
        prod_last = 1'b0; bias = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_data",  $signed(out_data), 0);
        check("rst_sat",   64'(out_sat), 0);
        check("rst_busy",  64'(busy), 0);
        check("rst_ready", 64'(prod_ready), 1);
        reset = 1'b0;

        // Single beats with rounding
        bias = 18'(0);
        beat(49152, 1'b1);  expect_result("one_3p0", 3, 1'b0);
        beat(8192, 1'b1);   expect_result("half_up", 1, 1'b0);
        beat(-8192, 1'b1);  expect_result("neg_half", 0, 1'b0);

        // Bias plus three beats: -2.0 + 3.0 = 1.0
        bias = 18'(-2);
        beat(16384, 1'b0); beat(16384, 1'b0); beat(16384, 1'b1);
        expect_result("bias3", 1, 1'b0);

        // Output clamp both directions
        bias = 18'(0);
        for (int i = 0; i < 4; i++) beat(64'sd2147483648, i == 3);
        expect_result("clamp_pos", 131071, 1'b1);
        for (int i = 0; i < 4; i++) beat(-64'sd2147483648, i == 3);
        expect_result("clamp_neg", -131072, 1'b1);

        // Backpressure: result held while out_ready low
        out_ready = 1'b0;
        beat(49152, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 1);
            check("bp_data",  $signed(out_data), 3);
            check("bp_sat",   64'(out_sat), 0);
            check("bp_ready", 64'(prod_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        prod_valid = 1'b1; prod_data = 41'(8192); prod_last = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 0);
        check("bp_release_ready", 64'(prod_ready), 1);
        @(posedge clk); #1;
        prod_valid = 1'b0; prod_last = 1'b0;
        expect_result("bp_next", 1, 1'b0);

        // Bubbles and ce low mid-window: 4 x 0.5... 4 x 1.0 = 4
        beat(16384, 1'b0);
        @(posedge clk); #1;
        beat(16384, 1'b0);
        ce = 1'b0;
        prod_valid = 1'b1; prod_data = 41'(16384); prod_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ce_busy",  64'(busy), 1);
            check("ce_ready", 64'(prod_ready), 1);
            check("ce_valid", 64'(out_valid), 0);
        end
        prod_valid = 1'b0; prod_last = 1'b0;
        ce = 1'b1;
        beat(16384, 1'b0);
        @(posedge clk); #1;
        beat(16384, 1'b1);
        expect_result("ce_gap", 4, 1'b0);

        // Reset mid-window discards the partial sum
        bias = 18'(5);
        beat(16384, 1'b0); beat(16384, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_busy",  64'(busy), 0);
        bias = 18'(0);
        beat(16384, 1'b1);
        expect_result("after_rst", 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
